// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Purpose  : 8N1 UART receiver front end. Synchronises the serial line,
//            detects the start edge, samples mid-bit and presents each byte
//            as dout with a one-cycle dout_vld strobe, or a one-cycle
//            frame_err strobe when the stop bit is sampled low.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BPS  = CLK_FREQ / BAUD;
  localparam int HALF = BPS / 2;
  localparam int CW   = (BPS > 1) ? $clog2(BPS) : 1;

  localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] C_BPS_M1  = CW'(BPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic            rx_dly_q;
  logic [CW-1:0]   cnt_clk_q;
  logic [2:0]      cnt_bit_q;
  logic [7:0]      shift_q;
  logic [7:0]      dout_q;
  logic            dout_vld_q;
  logic            frame_err_q;

  logic            w_fall;

  // Falling edge of the synchronised line; only the IDLE state acts on it.
  assign w_fall = rx_dly_q & ~rx_s_q;

  // Two-flop synchroniser plus one history flop; all reset to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_dly_q  <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_dly_q  <= rx_s_q;
    end
  end

  // Frame state machine: mid-bit sampling, shifting and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_clk_q   <= '0;
      cnt_bit_q   <= '0;
      shift_q     <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      dout_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_fall) begin
            state_q   <= START;
            cnt_clk_q <= '0;
            cnt_bit_q <= '0;
          end
        end
        START: begin
          // Half a bit after the edge: a high line means it was a glitch.
          // The counter restarts so later samples land at BPS-1.
          if (cnt_clk_q == C_HALF_M1) begin
            cnt_clk_q <= '0;
            state_q   <= rx_s_q ? IDLE : DATA;
          end else begin
            cnt_clk_q <= cnt_clk_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_clk_q == C_BPS_M1) begin
            cnt_clk_q <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            cnt_bit_q <= cnt_bit_q + 3'd1;
            if (cnt_bit_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_clk_q <= cnt_clk_q + CW'(1);
          end
        end
        STOP: begin
          // Returning to IDLE here lets the next start edge arrive
          // half a bit into this stop bit.
          if (cnt_clk_q == C_BPS_M1) begin
            cnt_clk_q <= '0;
            state_q   <= IDLE;
            if (rx_s_q) begin
              dout_q     <= shift_q;
              dout_vld_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_clk_q <= cnt_clk_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dout      = dout_q;
  assign dout_vld  = dout_vld_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_byte
// Purpose  : Self-checking bench for uart_rx_byte. A frame-level model built
//            from sample-instant arithmetic predicts every output each cycle;
//            directed scenarios add literal expectations on values and timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte;

  localparam int BPS  = 50_000_000 / 115200;
  localparam int HALF = BPS / 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] dout;
  logic       dout_vld;
  logic       frame_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  uart_rx_byte dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model. Line samples p[] are taken at each rising edge; the
  // receiver sees rx_s(c)=p[c-1] and its delayed copy p[c-2] in cycle c.
  // A frame is described only by its edge cycle E and the sample instants
  // E+HALF+k*BPS; expected outputs for the coming cycle follow from those.
  bit         q1, q2, q3;
  bit         m_act;
  int         m_E;
  logic [7:0] m_byte;
  logic [7:0] m_dout;
  bit         e_vld, e_ferr, e_busy;
  logic [7:0] e_dout;

  // Model step: decide the cycle just ended, yield expectations for the next.
  always @(posedge clk) begin
    int c, off, k;
    cyc++;
    if (!rst_n) begin
      q1 = 1; q2 = 1; q3 = 1;
      m_act = 0; m_dout = 8'h00; m_byte = 8'h00;
      e_vld = 0; e_ferr = 0; e_busy = 0; e_dout = 8'h00;
    end else begin
      c = cyc - 1;
      e_vld  = 0;
      e_ferr = 0;
      if (!m_act) begin
        if (q3 && !q2) begin
          m_act = 1;
          m_E   = c;
        end
      end else begin
        off = c - m_E - HALF;
        if (off >= 0 && (off % BPS) == 0) begin
          k = off / BPS;
          if (k == 0) begin
            if (q2) m_act = 0;
          end else if (k <= 8) begin
            m_byte[k-1] = q2;
          end else begin
            m_act = 0;
            if (q2) begin
              m_dout = m_byte;
              e_vld  = 1;
            end else begin
              e_ferr = 1;
            end
          end
        end
      end
      e_busy = m_act;
      e_dout = m_dout;
      q3 = q2; q2 = q1; q1 = rx;
    end
  end

  // Compare process plus event log of strobes for the directed checks.
  int         vld_cnt   = 0;
  int         ferr_cnt  = 0;
  bit         seen_busy = 0;
  int         vld_cyc[$];
  logic [7:0] vld_dat[$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk("dout",      int'(dout),      int'(e_dout));
      chk("dout_vld",  int'(dout_vld),  int'(e_vld));
      chk("frame_err", int'(frame_err), int'(e_ferr));
      chk("rx_busy",   int'(rx_busy),   int'(e_busy));
      if (dout_vld) begin
        vld_cnt++;
        vld_cyc.push_back(cyc);
        vld_dat.push_back(dout);
      end
      if (frame_err) ferr_cnt++;
      if (rx_busy) seen_busy = 1;
    end
  end

  // Drive the first nb bits of a 10-bit frame (start, data LSB first, stop).
  task automatic drive_bits(input logic [9:0] fr, input int nb);
    for (int i = 0; i < nb; i++) begin
      rx = fr[i];
      repeat (BPS) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    drive_bits({stop, b, 1'b0}, 10);
  endtask

  initial begin
    int t_fall, base, v0, f0;
    logic [7:0] rb;
    logic       rs;
    int         exp_v;
    logic [7:0] exp_last;

    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_dout",  int'(dout), 0);
    chk("reset_vld",   int'(dout_vld), 0);
    chk("reset_ferr",  int'(frame_err), 0);
    chk("reset_busy",  int'(rx_busy), 0);

    // Idle line
    repeat (10000) @(negedge clk);
    chk("idle_vld_cnt",  vld_cnt, 0);
    chk("idle_ferr_cnt", ferr_cnt, 0);
    chk("idle_busy",     int'(seen_busy), 0);
    chk("idle_dout",     int'(dout), 0);

    // Single 0x55 with latency
    t_fall = cyc;
    send(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    chk("b55_cnt",  vld_cnt, 1);
    chk("b55_data", int'(vld_dat[0]), 8'h55);
    chk("b55_lat",  vld_cyc[0] - t_fall, 4126);
    chk("b55_ferr", ferr_cnt, 0);

    // Back-to-back frames
    base = vld_cnt;
    send(8'h55, 1'b1);
    send(8'h66, 1'b1);
    send(8'hff, 1'b1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("b2b_cnt", vld_cnt - base, 3);
    if (vld_cnt - base == 3) begin
      chk("b2b_d0",  int'(vld_dat[base]),   8'h55);
      chk("b2b_d1",  int'(vld_dat[base+1]), 8'h66);
      chk("b2b_d2",  int'(vld_dat[base+2]), 8'hff);
      chk("b2b_gap1", vld_cyc[base+1] - vld_cyc[base],   4340);
      chk("b2b_gap2", vld_cyc[base+2] - vld_cyc[base+1], 4340);
    end

    // Framing error then clean frame
    v0 = vld_cnt; f0 = ferr_cnt;
    send(8'hA5, 1'b0);
    rx = 1'b1;
    repeat (BPS) @(negedge clk);
    chk("ferr_cnt",  ferr_cnt - f0, 1);
    chk("ferr_nvld", vld_cnt - v0, 0);
    chk("ferr_dout", int'(dout), 8'hff);
    send(8'h77, 1'b1);
    repeat (20) @(negedge clk);
    chk("after_ferr_cnt",  vld_cnt - v0, 1);
    chk("after_ferr_dout", int'(dout), 8'h77);

    // Short low glitch
    v0 = vld_cnt; f0 = ferr_cnt; seen_busy = 0;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (600) @(negedge clk);
    chk("glitch_busy", int'(seen_busy), 1);
    chk("glitch_idle", int'(rx_busy), 0);
    chk("glitch_vld",  vld_cnt - v0, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    chk("glitch_dout", int'(dout), 8'h77);

    // Reset during data bit 4
    v0 = vld_cnt; f0 = ferr_cnt;
    drive_bits({1'b1, 8'hC3, 1'b0}, 5);
    rx = 1'b0;
    repeat (200) @(negedge clk);
    #2 rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (20) @(negedge clk);
    chk("abort_dout", int'(dout), 0);
    chk("abort_vld",  vld_cnt - v0, 0);
    chk("abort_ferr", ferr_cnt - f0, 0);
    send(8'h99, 1'b1);
    repeat (20) @(negedge clk);
    chk("post_rst_cnt",  vld_cnt - v0, 1);
    chk("post_rst_dout", int'(dout), 8'h99);

    // Randomised frames, random stop errors and gaps
    v0 = vld_cnt; f0 = ferr_cnt;
    exp_v = 0; exp_last = 8'h99;
    for (int i = 0; i < 5; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      send(rb, rs);
      if (rs) begin
        exp_v++;
        exp_last = rb;
      end
      rx = 1'b1;
      repeat ($urandom_range(0, 300)) @(negedge clk);
    end
    repeat (BPS) @(negedge clk);
    chk("rand_vld_cnt",  vld_cnt - v0, exp_v);
    chk("rand_ferr_cnt", ferr_cnt - f0, 5 - exp_v);
    chk("rand_last",     int'(dout), int'(exp_last));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receiver front end. Deserialises the asynchronous serial line `rx` (8N1, LSB first) into bytes.
- Presents each byte as `dout` plus a one-cycle `dout_vld` strobe.
- Sits directly upstream of the frame/command parser: `dout`/`dout_vld` connect straight to the parser's `din`/`din_vld`.
- Also flags framing errors and reports line-busy status.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate in bits/s.
- BPS (localparam), CLK_FREQ/BAUD (integer division), clocks per bit. Default 434.
- HALF (localparam), BPS/2, mid-bit offset. Default 217.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- dout  output  8  last correctly received byte.
- dout_vld  output  1  one-cycle strobe; dout is valid in the same cycle.
- frame_err  output  1  one-cycle strobe; stop bit was sampled low.
- rx_busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset: one clock, rst_n asynchronous active-low.
  - Sync flops and edge-history flop reset to 1 (idle line).
  - state=IDLE, counters=0, shift register=0.
  - dout=8'h00, dout_vld=0, frame_err=0, rx_busy=0.
  - Reset asserted mid-frame aborts the frame; no strobe is produced.
- Synchroniser: `rx` passes through 2 flops to give rx_s; rx_d is rx_s delayed one cycle.
- Falling edge: rx_d==1 && rx_s==0. Only acted on in IDLE.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: on a falling edge, go to START and clear the baud counter (cnt_clk) and the bit counter (cnt_bit). Call this edge cycle E.
  - cnt_clk counts 0..BPS-1 and wraps. Sample strobe occurs at cnt_clk==HALF-1 in START and at cnt_clk==BPS-1 thereafter. Sample instants are E+HALF+k*BPS:
    - k=0: start bit.
    - k=1..8: data bits 0..7.
    - k=9: stop bit.
  - START: at the k=0 sample:
    - rx_s==1 (glitch): return to IDLE. No strobe, dout unchanged.
    - rx_s==0: go to DATA.
  - DATA: at each sample, shift rx_s into bit 7 of the shift register (right shift, so LSB arrives first) and increment cnt_bit. After the 8th sample (cnt_bit wraps 7->0), go to STOP.
  - STOP: at the k=9 sample:
    - rx_s==1: dout <= shift register and dout_vld=1 for exactly one cycle, in cycle E+HALF+9*BPS+1.
    - rx_s==0: frame_err=1 for one cycle at the same cycle; dout is unchanged.
    - Either way, return to IDLE in that same cycle.
- Back-to-back frames: a new falling edge is accepted from the first IDLE cycle, i.e. half a bit into the previous stop bit. No idle gap is required.
- Latency: from the rx pin falling to the dout_vld strobe is 2 (sync) + HALF + 9*BPS + 1 clocks. With defaults this is 4126 clocks.
- Line held low from reset: an edge is detected (sync reset value is 1). This produces a frame of 0x00 and a frame_err strobe, then IDLE. No further frames until the line returns high and falls again.
- dout_vld and frame_err are mutually exclusive and never high in consecutive cycles.
- rx_busy is combinational from state; it is high from cycle E+1 through the stop-sample cycle.
- No back-pressure: the downstream stage must accept dout_vld unconditionally.

Test Plan:
- Reset, then hold rx=1 for 10000 clocks -> dout=8'h00, dout_vld and frame_err never assert, rx_busy=0.
- Default parameters, send byte 8'h55 (start 0, bits 1,0,1,0,1,0,1,0, stop 1) -> single dout_vld pulse 4126 clocks after the rx fall, dout=8'h55, frame_err stays 0.
- Send 8'h55, 8'h66, 8'hff back-to-back with no idle between frames -> three dout_vld pulses spaced 10*BPS=4340 clocks apart, with dout 8'h55, 8'h66, 8'hff in order.
- Send 8'hA5 with the stop bit driven 0 -> frame_err pulses once, no dout_vld, dout keeps its previous value. Then a clean 8'h77 -> dout_vld with dout=8'h77.
- Low glitch of 100 clocks (< HALF) on idle rx -> rx_busy high until the start sample, then IDLE. No strobes, dout unchanged.
- Assert rst_n=0 during data bit 4 of a frame, release, then send 8'h99 -> no strobe from the aborted frame, dout=8'h00 after reset, and the next dout_vld has dout=8'h99.
